bus_arbiter_mux: RTL

Parametrised, registered successor to the datapath's combinational 32-to-1 bus multiplexer. It selects one of `NUM_SOURCES` register/unit outputs onto the shared CPU bus, either by explicit select code (legacy mode) or by round-robin arbitration over request lines. It holds the chosen word in an output register with a valid/ready handshake. It also returns a one-cycle grant to the winning source, so producers know their data was taken.

---
 rtl/bus_arbiter_mux.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/bus_arbiter_mux.sv
// bus_arbiter_mux: registered bus source selector with direct-select and
// round-robin arbitration, valid/ready output handshake and a one-cycle grant
// returned to the source whose word was loaded.

module bus_arbiter_mux #(
    parameter int DATA_WIDTH  = 32,
    parameter int NUM_SOURCES = 32,
    parameter int SEL_WIDTH   = 5
) (
    input  logic                              clock,
    input  logic                              clear,
    input  logic                              enable,
    input  logic                              mode,
    input  logic [SEL_WIDTH-1:0]              select,
    input  logic [NUM_SOURCES-1:0]            req,
    input  logic                              lock,
    input  logic [NUM_SOURCES*DATA_WIDTH-1:0] data_in,
    input  logic                              bus_ready,
    output logic [DATA_WIDTH-1:0]             bus_out,
    output logic                              bus_valid,
    output logic [NUM_SOURCES-1:0]            grant,
    output logic [SEL_WIDTH-1:0]              grant_id
);

    // Pointer resets to the last source so the rotation starts at source 0.
    localparam logic [SEL_WIDTH-1:0] PTR_RESET = SEL_WIDTH'(NUM_SOURCES - 1);

    logic [SEL_WIDTH-1:0]   ptr;
    logic                   load_slot;
    logic                   lock_hit;
    logic                   direct_hit;
    logic                   rr_hit;
    logic [SEL_WIDTH-1:0]   rr_id;
    logic [NUM_SOURCES-1:0] rr_upper;
    logic                   win_valid;
    logic [SEL_WIDTH-1:0]   win_id;
    logic                   win_from_rr;
    logic [DATA_WIDTH-1:0]  win_data;
    logic [NUM_SOURCES-1:0] win_onehot;

    // The output register may take a new word when empty or being drained.
    assign load_slot = !bus_valid || bus_ready;

    // Burst lock holds the current owner while it keeps requesting.
    always_comb begin
        lock_hit = 1'b0;
        for (int i = 0; i < NUM_SOURCES; i++) begin
            if (lock && (int'(grant_id) == i) && req[i]) begin
                lock_hit = 1'b1;
            end
        end
    end

    // Direct select wins only for an in-range code whose source is requesting.
    always_comb begin
        direct_hit = 1'b0;
        for (int i = 0; i < NUM_SOURCES; i++) begin
            if ((int'(select) == i) && req[i]) begin
                direct_hit = 1'b1;
            end
        end
    end

    // Round-robin: lowest request above ptr, else lowest request overall (wrap).
    always_comb begin
        rr_upper = '0;
        for (int i = 0; i < NUM_SOURCES; i++) begin
            rr_upper[i] = req[i] && (i > int'(ptr));
        end
        rr_hit = |req;
        rr_id  = '0;
        for (int i = NUM_SOURCES - 1; i >= 0; i--) begin
            if (req[i]) begin
                rr_id = SEL_WIDTH'(i);
            end
        end
        for (int i = NUM_SOURCES - 1; i >= 0; i--) begin
            if (rr_upper[i]) begin
                rr_id = SEL_WIDTH'(i);
            end
        end
    end

    // Pick the winner: lock overrides both modes and leaves ptr alone.
    always_comb begin
        win_valid   = 1'b0;
        win_id      = grant_id;
        win_from_rr = 1'b0;
        if (lock_hit) begin
            win_valid = 1'b1;
            win_id    = grant_id;
        end else if (mode) begin
            win_valid   = rr_hit;
            win_id      = rr_id;
            win_from_rr = rr_hit;
        end else begin
            win_valid = direct_hit;
            win_id    = select;
        end
    end

    // Steer the winning source's word and build its one-hot grant.
    always_comb begin
        win_data   = '0;
        win_onehot = '0;
        for (int i = 0; i < NUM_SOURCES; i++) begin
            if (int'(win_id) == i) begin
                win_data      = data_in[i*DATA_WIDTH +: DATA_WIDTH];
                win_onehot[i] = 1'b1;
            end
        end
    end

    // Output register, grant pulse and rotation pointer; stalled words hold.
    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            bus_out   <= '0;
            bus_valid <= 1'b0;
            grant     <= '0;
            grant_id  <= '0;
            ptr       <= PTR_RESET;
        end else begin
            grant <= '0;
            if (load_slot) begin
                if (enable && win_valid) begin
                    bus_out   <= win_data;
                    bus_valid <= 1'b1;
                    grant     <= win_onehot;
                    grant_id  <= win_id;
                    if (win_from_rr) begin
                        ptr <= win_id;
                    end
                end else if (bus_ready) begin
                    bus_valid <= 1'b0;
                end
            end
        end
    end

endmodule
